mdu_execute: RTL

- Iterative RV32M multiply/divide unit in the execute stage.
- Consumes ALUControlE, SrcAE and SrcBE from the D→E pipeline register.
- Stalls the pipeline while the operation runs, then presents a 32-bit result alongside the ALU result for the E→M register.
- Radix-2 algorithm: one bit per cycle.

---
 rtl/mdu_execute.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mdu_execute.sv
// Iterative RV32M multiply/divide unit for the execute stage: radix-2, one bit per cycle,
// stalls the pipeline while running and registers the result on entry to DONE.
module mdu_execute #(
  parameter int unsigned WIDTH   = 32,
  parameter logic [1:0]  MDU_SEL = 2'b11
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr,
  input  logic [4:0]       ALUControlE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  output logic [WIDTH-1:0] MDUResultE,
  output logic             MDUDoneE,
  output logic             MDUStallE,
  output logic             MDUBusy,
  output logic [1:0]       dbg_state_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic             done_q;

  logic [2:0]       funct3;
  logic             mdu_op, is_div, a_signed, b_signed, a_neg, b_neg, start_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             div_zero, div_ovf;
  logic [WIDTH-1:0] special_res;

  // Decode the op presented in E: operand magnitudes, result sign and divide special cases.
  always_comb begin
    funct3   = ALUControlE[2:0];
    mdu_op   = (ALUControlE[4:3] == MDU_SEL);
    is_div   = funct3[2];
    a_signed = is_div ? ~funct3[0] : ((funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10));
    b_signed = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
    a_neg    = a_signed & SrcAE[WIDTH-1];
    b_neg    = b_signed & SrcBE[WIDTH-1];
    mag_a    = a_neg ? -SrcAE : SrcAE;
    mag_b    = b_neg ? -SrcBE : SrcBE;
    // Remainder takes the dividend's sign; everything else takes the product/quotient sign.
    start_neg = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero  = is_div && (SrcBE == '0);
    div_ovf   = is_div && !funct3[0] && (SrcAE == MIN_NEG) && (SrcBE == '1);
    special_res = '0;
    if (div_zero) begin
      special_res = funct3[1] ? SrcAE : '1;
    end else if (div_ovf) begin
      special_res = funct3[1] ? '0 : MIN_NEG;
    end
  end

  logic [WIDTH:0]     add_sum, sub_diff;
  logic [WIDTH-1:0]   acc_nx, quo_nx;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   rem_s, quo_s, iter_res;

  // One iteration: {acc,quo} is the shifting product for multiply, remainder/quotient for divide.
  always_comb begin
    add_sum  = {1'b0, acc_q} + (quo_q[0] ? {1'b0, opb_q} : '0);
    sub_diff = {acc_q, quo_q[WIDTH-1]} - {1'b0, opb_q};
    if (op_q[2]) begin
      if (!sub_diff[WIDTH]) begin
        acc_nx = sub_diff[WIDTH-1:0];
        quo_nx = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx = {acc_q[WIDTH-2:0], quo_q[WIDTH-1]};
        quo_nx = {quo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      {acc_nx, quo_nx} = {add_sum, quo_q[WIDTH-1:1]};
    end
    prod_s = neg_q ? -{acc_nx, quo_nx} : {acc_nx, quo_nx};
    rem_s  = neg_q ? -acc_nx : acc_nx;
    quo_s  = neg_q ? -quo_nx : quo_nx;
    if (op_q[2]) begin
      iter_res = op_q[1] ? rem_s : quo_s;
    end else begin
      iter_res = (op_q[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    quo_d    = quo_q;
    opb_d    = opb_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (mdu_op && !clr) begin
          op_d    = funct3;
          neg_d   = start_neg;
          count_d = '0;
          acc_d   = '0;
          quo_d   = is_div ? mag_a : mag_b;
          opb_d   = is_div ? mag_b : mag_a;
          if (div_zero || div_ovf) begin
            state_d  = DONE;
            result_d = special_res;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (clr) begin
          state_d = IDLE;
        end else begin
          acc_d   = acc_nx;
          quo_d   = quo_nx;
          count_d = count_q + CW'(1);
          if (count_q == LAST_ITER) begin
            state_d  = DONE;
            result_d = iter_res;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      quo_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      quo_q    <= quo_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      done_q   <= (state_d == DONE);
    end
  end

  // Stall is gated by reset so the hazard unit releases immediately when n_rst drops.
  assign MDUStallE   = n_rst & (((state_q == IDLE) & mdu_op & ~clr) | (state_q == RUN));
  assign MDUBusy     = (state_q == RUN);
  assign MDUDoneE    = done_q;
  assign MDUResultE  = result_q;
  assign dbg_state_o = state_q;

endmodule
